masked_serial_adder: RTL and testbench
======================================

// Module: masked_serial_adder
// PURPOSE
// - Bit-serial W-bit adder on Boolean-masked (d-share) operands; sum of W+1 bits incl. carry-out.
// - Time-multiplexes one instance of the masked half adder adder_1bit, which has 2-cycle latency.
// - Each bit runs two half-adder passes; full-adder carry = c1 ^ c2 (c1, c2 never both 1).
// - Sits downstream of operand registers in the masked arithmetic datapath; replaces a wide parallel adder where area matters.
// PARAMETERS
// - d     2   number of shares (masking order d-1)
// - W     8   operand width in bits
// PORTS
// - clk      in   1            clock, rising edge
// - rst_n    in   1            synchronous reset, active low
// - start    in   1            operand-valid strobe; accepted only when ready=1
// - ready    out  1            1 in IDLE
// - a_in     in   d*W          operand a; bit j shares at [j*d +: d]
// - b_in     in   d*W          operand b; same layout
// - rnd      in   d*(d-1)/2    fresh randomness for adder_1bit, new value every cycle
// - sum_out  out  d*(W+1)      masked sum; bit j at [j*d +: d]; bit W = carry-out
// - done     out  1            one-cycle pulse: sum_out valid
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state IDLE, ready=1, done=0, sum_out=0, carry shares=0, bit/phase counters=0. Aborts any running add; no done.
// - States: IDLE -> RUN on start&ready; RUN -> DONE after bit W-1 phase 5; DONE -> IDLE unconditionally after 1 cycle.
// - On accept: latch a_in, b_in into operand regs; carry shares <= 0; bit=0; phase=0. Inputs may change afterwards.
// - start while not ready is ignored: not queued, no effect on the running add.
// - RUN: each bit j takes 6 cycles (phase 0..5).
// - Phases 0-2: adder_1bit inputs = (a_j, b_j), held constant.
//   - End of phase 2: capture s1 = sum-out shares, c1 = carry-out shares.
// - Phases 3-5: adder_1bit inputs = (s1, carry), held constant.
//   - End of phase 5: sum_reg bit j <= sum-out shares; carry <= c1 ^ c2 (share-wise XOR, c2 = carry-out shares).
//   - Then bit++ and phase <= 0.
// - Half-adder output is sampled only at the end of the 3rd cycle of a constant-input window; never combinationally forwarded to its own inputs.
// - After bit W-1: sum_reg bit W <= carry; enter DONE.
// - done=1 exactly in DONE, i.e. the cycle 6*W+1 after the accepting edge; ready=0 from accept through DONE.
// - sum_out holds its value from DONE until the next accept, then holds stale until the next DONE.
//   - Consumers use only the done strobe.
// - Back-to-back: start asserted in DONE is ignored (ready=0); earliest accept is the first IDLE cycle.
// - Masking: no register or wire ever combines shares of one bit; shares are only recombined in the bench.
// - rnd is consumed every RUN cycle; the bench must supply fresh values each cycle.
// - Counter widths: phase 3 bits, saturating at 5; bit counter $clog2(W) bits, no wrap past W-1.
// STRUCTURE
// - Shared package masked_pkg: localparam function and_nrnd(d) = d*(d-1)/2; BIT_CYCLES = 6; state enum {IDLE, RUN, DONE}.
// - Sub-module: one adder_1bit #(.d(d)) instance.
// - Input mux (a_j, b_j)/(s1, carry) is selected by registered phase>=3 only, so the mux select is glitch-free.
// - All else in this file: FSM, counters, operand/sum/carry/s1/c1 registers.
// TESTING (d=2, W=4; operands split into random shares; sum recombined by XOR of shares)
// - a=5, b=3, start 1 cycle -> done pulse exactly 25 cycles after accept edge; sum=5'b01000; ready returns 1 next cycle.
// - a=15, b=1 -> sum=5'b10000 (carry ripples all 4 bits); a=15, b=15 -> sum=5'b11110.
// - a=0, b=0; then same a=9, b=6 with 3 different share splits and random rnd -> sum=0; sum=15 every time.
// - start held high through a whole add -> exactly one add executes; next accept only in the first IDLE cycle after done.
//   - Operands changed mid-run -> result still matches the latched operands.
// - rst_n=0 at bit 2 phase 4 -> next cycle ready=1, done=0, sum_out=0; then a=7, b=7 -> sum=14, with no done from the aborted add.
// - Exhaustive sweep of all 256 (a,b) pairs, random shares and rnd -> sum == a+b for every pair.

Source files
------------

// File: rtl/masked_pkg.sv
// Shared definitions for the masked arithmetic datapath: the FSM state type,
// per-bit schedule constants and helpers that size and index the randomness bus.
package masked_pkg;

    // Cycles spent on one operand bit: two half-adder passes of three cycles each
    localparam int BIT_CYCLES = 6;

    // First phase of the second half-adder pass (inputs become s1 / carry)
    localparam int PH_SWITCH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fresh random bits needed by one masked AND gadget with n shares
    function automatic int and_nrnd(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Position of the random bit shared by cross terms (i,j) and (j,i), i < j
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/adder_1bit.sv
// Masked half adder on d-share Boolean operands. Sum shares are the share-wise
// XOR of the inputs; carry shares come from a domain-oriented masked AND whose
// cross products are refreshed with one random bit per share pair and registered
// before being compressed, so glitches cannot combine shares of one value.
// Latency is two cycles; outputs are correct once inputs have been held for two
// cycles.
module adder_1bit
    import masked_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                     clk,
    input  logic [d-1:0]             x,
    input  logic [d-1:0]             y,
    input  logic [and_nrnd(d)-1:0]   rnd,
    output logic [d-1:0]             s,
    output logic [d-1:0]             c
);

    logic [d*d-1:0] prod_d, prod_q;
    logic [d-1:0]   sum1_d, sum1_q;
    logic [d-1:0]   s_d, s_q;
    logic [d-1:0]   c_d, c_q;

    // First stage: all share cross products, off-diagonal ones masked with fresh randomness
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i < j) begin
                    prod_d[i*d+j] = (x[i] & y[j]) ^ rnd[pair_idx(i, j, d)];
                end else if (i > j) begin
                    prod_d[i*d+j] = (x[i] & y[j]) ^ rnd[pair_idx(j, i, d)];
                end else begin
                    prod_d[i*d+j] = x[i] & y[j];
                end
            end
        end
        sum1_d = x ^ y;
    end

    // Second stage: compress each domain's registered products into one carry share
    always_comb begin
        c_d = '0;
        for (int i = 0; i < d; i++) begin
            c_d[i] = ^prod_q[i*d +: d];
        end
        s_d = sum1_q;
    end

    // Pipeline registers for both stages (data only, no reset needed)
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        sum1_q <= sum1_d;
        s_q    <= s_d;
        c_q    <= c_d;
    end

    assign s = s_q;
    assign c = c_q;

endmodule

// File: rtl/masked_serial_adder.sv
// Bit-serial W-bit adder on Boolean-masked operands. One masked half adder is
// reused twice per bit: first on (a_j, b_j) giving (s1, c1), then on
// (s1, carry) giving (sum_j, c2). The next carry is c1 ^ c2 share-wise, which
// is exact because c1 and c2 can never both be 1. Each pass holds the adder
// inputs for three cycles and samples its output at the end of the third.
module masked_serial_adder
    import masked_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     ready,
    input  logic [d*W-1:0]           a_in,
    input  logic [d*W-1:0]           b_in,
    input  logic [and_nrnd(d)-1:0]   rnd,
    output logic [d*(W+1)-1:0]       sum_out,
    output logic                     done
);

    localparam int             BIT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(W - 1);
    localparam logic [2:0]     PH_MID   = 3'(PH_SWITCH - 1);
    localparam logic [2:0]     PH_LAST  = 3'(BIT_CYCLES - 1);
    localparam logic [2:0]     PH_SEL   = 3'(PH_SWITCH);

    state_t state_q, state_d;

    logic [2:0]           phase_d, phase_q;
    logic [BIT_W-1:0]     bit_d, bit_q;
    logic                 sel_d, sel_q;
    logic [d-1:0]         carry_d, carry_q;
    logic [d*(W+1)-1:0]   sum_out_d, sum_out_q;

    logic [d*W-1:0]       a_d, a_q;
    logic [d*W-1:0]       b_d, b_q;
    logic [d-1:0]         s1_d, s1_q;
    logic [d-1:0]         c1_d, c1_q;
    logic [d*W-1:0]       sum_reg_d, sum_reg_q;

    logic                 accept;
    logic [d-1:0]         a_bit, b_bit;
    logic [d-1:0]         ha_x, ha_y;
    logic [d-1:0]         ha_s, ha_c;
    logic [d-1:0]         carry_new;
    logic [d*W-1:0]       sum_next;

    assign accept = start && (state_q == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one add runs to completion, DONE lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (phase_q == PH_LAST && bit_q == LAST_BIT) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE:    ready = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    // Pick the shares of the current operand bit
    always_comb begin
        a_bit = a_q[d-1:0];
        b_bit = b_q[d-1:0];
        for (int j = 0; j < W; j++) begin
            if (bit_q == BIT_W'(j)) begin
                a_bit = a_q[j*d +: d];
                b_bit = b_q[j*d +: d];
            end
        end
    end

    // Half-adder input mux, steered only by a registered select so it never glitches
    always_comb begin
        ha_x = sel_q ? s1_q    : a_bit;
        ha_y = sel_q ? carry_q : b_bit;
    end

    adder_1bit #(.d(d)) u_ha (
        .clk (clk),
        .x   (ha_x),
        .y   (ha_y),
        .rnd (rnd),
        .s   (ha_s),
        .c   (ha_c)
    );

    // Schedule: counters, operand capture, pass results and sum assembly
    always_comb begin
        phase_d   = phase_q;
        bit_d     = bit_q;
        sel_d     = sel_q;
        carry_d   = carry_q;
        sum_out_d = sum_out_q;
        a_d       = a_q;
        b_d       = b_q;
        s1_d      = s1_q;
        c1_d      = c1_q;
        sum_reg_d = sum_reg_q;

        carry_new = c1_q ^ ha_c;
        sum_next  = sum_reg_q;
        for (int j = 0; j < W; j++) begin
            if (bit_q == BIT_W'(j)) begin
                sum_next[j*d +: d] = ha_s;
            end
        end

        if (accept) begin
            a_d     = a_in;
            b_d     = b_in;
            carry_d = '0;
            bit_d   = '0;
            phase_d = '0;
            sel_d   = 1'b0;
        end else if (state_q == RUN) begin
            if (phase_q == PH_MID) begin
                s1_d = ha_s;
                c1_d = ha_c;
            end
            if (phase_q == PH_LAST) begin
                sum_reg_d = sum_next;
                carry_d   = carry_new;
                phase_d   = '0;
                if (bit_q == LAST_BIT) begin
                    sum_out_d = {carry_new, sum_next};
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end else begin
                phase_d = phase_q + 3'd1;
            end
            sel_d = (phase_d >= PH_SEL);
        end
    end

    // Control and visible-result registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= '0;
            bit_q     <= '0;
            sel_q     <= 1'b0;
            carry_q   <= '0;
            sum_out_q <= '0;
        end else begin
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sel_q     <= sel_d;
            carry_q   <= carry_d;
            sum_out_q <= sum_out_d;
        end
    end

    // Datapath registers, always rewritten before use so they carry no reset
    always_ff @(posedge clk) begin
        a_q       <= a_d;
        b_q       <= b_d;
        s1_q      <= s1_d;
        c1_q      <= c1_d;
        sum_reg_q <= sum_reg_d;
    end

    assign sum_out = sum_out_q;

endmodule

// File: tb/tb_masked_serial_adder.sv
// Bench for masked_serial_adder with d=2, W=4. Operands are split into random
// shares, the sum is recombined by XOR of shares. A cycle-level model derived
// from the accept/latency rules predicts ready, done and the recombined result.
module tb_masked_serial_adder;

    localparam int D   = 2;
    localparam int W   = 4;
    localparam int NB  = W + 1;
    localparam int NR  = D * (D - 1) / 2;
    localparam int LAT = 6 * W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              ready;
    logic              done;
    logic [D*W-1:0]    a_in = '0;
    logic [D*W-1:0]    b_in = '0;
    logic [NR-1:0]     rnd = '0;
    logic [D*NB-1:0]   sum_out;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt  = 0;
    int m_pend = 0;
    int m_sum  = 0;

    always #5 clk = ~clk;

    masked_serial_adder #(.d(D), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ready   (ready),
        .a_in    (a_in),
        .b_in    (b_in),
        .rnd     (rnd),
        .sum_out (sum_out),
        .done    (done)
    );

    function automatic int recomb(input logic [D*NB-1:0] v, input int nb);
        int r;
        r = 0;
        for (int j = 0; j < nb; j++) r[j] = ^v[j*D +: D];
        return r;
    endfunction

    function automatic logic [D*W-1:0] split(input int v);
        logic [D*W-1:0] r;
        logic [31:0]    r32;
        logic           acc;
        r = '0;
        for (int j = 0; j < W; j++) begin
            acc = v[j];
            for (int s = 0; s < D - 1; s++) begin
                r32 = $urandom;
                r[j*D+s] = r32[0];
                acc = acc ^ r32[0];
            end
            r[j*D+D-1] = acc;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Fresh randomness every cycle
    initial begin
        logic [31:0] r32;
        forever begin
            @(negedge clk);
            r32 = $urandom;
            rnd = r32[NR-1:0];
        end
    end

    // Model: an accept happens in IDLE on start; done falls in cycle LAT after it
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_sum = 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  = 1;
                m_pend = recomb({{D{1'b0}}, a_in}, W) + recomb({{D{1'b0}}, b_in}, W);
            end
        end else if (m_cnt == LAT) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == LAT) m_sum = m_pend;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("ready", 32'(ready), 32'(m_cnt == 0));
        check("done", 32'(done), 32'(m_cnt == LAT));
        check("sum_hold", 32'(recomb(sum_out, NB)), 32'(m_sum));
    end

    task automatic wait_ready();
        int g;
        g = 0;
        while (ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_add(input int a, input int b, output int res, output int lat);
        wait_ready();
        a_in  = split(a);
        b_in  = split(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        res = recomb(sum_out, NB);
    endtask

    initial begin
        int res;
        int lat;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum_raw", 32'(sum_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_add(5, 3, res, lat);
        check("lat_5_3", 32'(lat), 32'd25);
        check("sum_5_3", 32'(res), 32'b01000);
        @(negedge clk);
        check("ready_after_done", 32'(ready), 32'd1);

        do_add(15, 1, res, lat);
        check("sum_15_1", 32'(res), 32'b10000);
        do_add(15, 15, res, lat);
        check("sum_15_15", 32'(res), 32'b11110);
        do_add(0, 0, res, lat);
        check("sum_0_0", 32'(res), 32'd0);
        for (int k = 0; k < 3; k++) begin
            do_add(9, 6, res, lat);
            check("sum_9_6", 32'(res), 32'd15);
        end

        // start held high through a whole add, operands changed mid-run
        wait_ready();
        a_in  = split(9);
        b_in  = split(6);
        start = 1'b1;
        repeat (5) @(negedge clk);
        a_in = split(2);
        b_in = split(3);
        wait_done(lat);
        check("hold_lat", 32'(lat), 32'd21);
        check("hold_sum", 32'(recomb(sum_out, NB)), 32'd15);
        @(negedge clk);
        check("hold_first_idle", 32'(ready), 32'd1);
        @(negedge clk);
        check("hold_reaccept", 32'(ready), 32'd0);
        start = 1'b0;
        wait_done(lat);
        check("hold_second_sum", 32'(recomb(sum_out, NB)), 32'd5);

        // reset in the middle of bit 2, phase 4
        wait_ready();
        a_in  = split(5);
        b_in  = split(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 17) begin
            @(negedge clk);
            lat++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum_raw", 32'(sum_out), 32'd0);
        rst_n = 1'b1;
        do_add(7, 7, res, lat);
        check("sum_7_7", 32'(res), 32'd14);
        check("lat_7_7", 32'(lat), 32'd25);

        // every operand pair
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_add(a, b, res, lat);
                check("sweep", 32'(res), 32'(a + b));
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
